// File: rtl/seq_ripple_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock, carry held
// in a register between slices; result published only when all are done.
module seq_ripple_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic             c_q;
  logic             c_d;
  logic [IW-1:0]    idx_q;
  logic             last;

  logic [CHUNK-1:0] ach;
  logic [CHUNK-1:0] bch;
  logic [CHUNK:0]   add;
  logic [CHUNK-1:0] s;
  logic             cmsb;

  // Operands shift down so the active slice is always the low chunk;
  // the partial result shifts in from the top.
  always_comb begin
    ach   = a_q[CHUNK-1:0];
    bch   = b_q[CHUNK-1:0];
    add   = {1'b0, ach} + {1'b0, bch} + (CHUNK+1)'(c_q);
    s     = add[CHUNK-1:0];
    c_d   = add[CHUNK];
    cmsb  = s[CHUNK-1] ^ ach[CHUNK-1] ^ bch[CHUNK-1];
    acc_d = (acc_q >> CHUNK) | (WIDTH'(s) << (WIDTH - CHUNK));
    last  = (idx_q == IW'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      c_q     <= 1'b0;
      idx_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            c_q     <= sub | cin;
            idx_q   <= '0;
            busy    <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q   <= a_q >> CHUNK;
          b_q   <= b_q >> CHUNK;
          c_q   <= c_d;
          acc_q <= acc_d;
          idx_q <= idx_q + IW'(1);
          if (last) begin
            sum     <= acc_d;
            cout    <= c_d;
            ovf     <= c_d ^ cmsb;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
